// File: rtl/keypad_pkg.sv
// Shared constants, key codes, FSM state type and the one-hot decoder
// for the keypad entry controller.
package keypad_pkg;

    // Raw one-hot codes as they arrive on the keypad bus
    localparam logic [15:0] OH_DIGIT0 = 16'h0008;
    localparam logic [15:0] OH_DIGIT1 = 16'h0080;
    localparam logic [15:0] OH_DIGIT2 = 16'h0040;
    localparam logic [15:0] OH_DIGIT3 = 16'h0020;
    localparam logic [15:0] OH_DIGIT4 = 16'h0800;
    localparam logic [15:0] OH_DIGIT5 = 16'h0400;
    localparam logic [15:0] OH_DIGIT6 = 16'h0200;
    localparam logic [15:0] OH_DIGIT7 = 16'h8000;
    localparam logic [15:0] OH_DIGIT8 = 16'h4000;
    localparam logic [15:0] OH_DIGIT9 = 16'h2000;
    localparam logic [15:0] OH_ENTER  = 16'h0001;
    localparam logic [15:0] OH_BKSP   = 16'h0002;
    localparam logic [15:0] OH_CLEAR  = 16'h0004;

    // Key codes presented on key_code; 0-9 are the digits themselves
    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_NONE  = 4'hF;

    // Marker for an unused position in the BCD entry buffer
    localparam logic [3:0] BLANK_NIBBLE = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_DB,
        ST_ACT,
        ST_HELD,
        ST_REL_DB
    } kp_state_e;

    // Map a synchronised one-hot code to a key code; anything that is not
    // exactly one recognised key (zero, multi-hot, unused columns) is NONE.
    function automatic logic [3:0] decode_key(input logic [15:0] code);
        logic [3:0] key;
        case (code)
            OH_DIGIT0: key = 4'd0;
            OH_DIGIT1: key = 4'd1;
            OH_DIGIT2: key = 4'd2;
            OH_DIGIT3: key = 4'd3;
            OH_DIGIT4: key = 4'd4;
            OH_DIGIT5: key = 4'd5;
            OH_DIGIT6: key = 4'd6;
            OH_DIGIT7: key = 4'd7;
            OH_DIGIT8: key = 4'd8;
            OH_DIGIT9: key = 4'd9;
            OH_ENTER:  key = KEY_ENTER;
            OH_BKSP:   key = KEY_BKSP;
            OH_CLEAR:  key = KEY_CLEAR;
            default:   key = KEY_NONE;
        endcase
        return key;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Synchronises the raw keypad bus, decodes it, and debounces press and
// release so that each physical press yields exactly one ACT cycle.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] onehot_i,
    output logic        act_o,
    output logic [3:0]  act_code_o,
    output logic        key_pulse_o,
    output logic [3:0]  key_code_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [15:0]   s1_q, s2_q;
    kp_state_e     state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          key_pulse_q;
    logic [3:0]    key_code_q, key_code_d;
    logic [3:0]    key;

    assign key = decode_key(s2_q);

    // Two-flop synchroniser for the asynchronous keypad bus
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse s1/s2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= onehot_i;
            s2_q <= s1_q;
        end
    end

    // Press/release debounce: next state, candidate key and sample counter
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (key != KEY_NONE) begin
                    cand_d = key;
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = ST_ACT;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_PRESS_DB;
                        cnt_d   = CW'(1);
                    end
                end
            end
            ST_PRESS_DB: begin
                if (key == cand_q) begin
                    if (int'(cnt_q) + 1 >= DEBOUNCE_CYCLES) begin
                        state_d = ST_ACT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_ACT: begin
                state_d = ST_HELD;
                cnt_d   = '0;
            end
            ST_HELD: begin
                // A different key while held only starts the release count
                if (key != cand_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_REL_DB;
                        cnt_d   = CW'(1);
                    end
                end
            end
            ST_REL_DB: begin
                if (key == cand_q) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (int'(cnt_q) + 1 >= DEBOUNCE_CYCLES) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state, candidate and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cand_q  <= KEY_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    assign act_o      = (state_q == ST_ACT);
    assign act_code_o = cand_q;

    // Latch the accepted key code on the ACT cycle
    always_comb begin
        key_code_d = key_code_q;
        if (act_o) begin
            key_code_d = cand_q;
        end
    end

    // Registered key strobe and code, aligned with the buffer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_pulse_q <= 1'b0;
            key_code_q  <= KEY_NONE;
        end else begin
            key_pulse_q <= act_o;
            key_code_q  <= key_code_d;
        end
    end

    assign key_pulse_o = key_pulse_q;
    assign key_code_o  = key_code_q;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: edits a BCD entry buffer from debounced key
// actions and hands completed numbers out over a valid/ready handshake.
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int NDIGITS         = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [15:0]                    onehot,
    output logic [4*NDIGITS-1:0]           buf_value,
    output logic [$clog2(NDIGITS+1)-1:0]   digit_cnt,
    output logic                           key_pulse,
    output logic [3:0]                     key_code,
    output logic [4*NDIGITS-1:0]           out_value,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           err_pulse
);

    localparam int W     = 4 * NDIGITS;
    localparam int CNT_W = $clog2(NDIGITS + 1);

    localparam logic [W-1:0] ALL_BLANK = {NDIGITS{BLANK_NIBBLE}};
    localparam logic [W-1:0] TOP_BLANK = W'(BLANK_NIBBLE) << (W - 4);

    logic             act;
    logic [3:0]       act_code;

    logic [W-1:0]     buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     oval_q, oval_d;
    logic             ov_q, ov_d;
    logic             err_q, err_d;

    keypad_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .onehot_i    (onehot),
        .act_o       (act),
        .act_code_o  (act_code),
        .key_pulse_o (key_pulse),
        .key_code_o  (key_code)
    );

    // Buffer editing, commit on ENTER and consumer handshake
    always_comb begin
        buf_d  = buf_q;
        cnt_d  = cnt_q;
        oval_d = oval_q;
        ov_d   = ov_q;
        err_d  = 1'b0;

        // out_value is left untouched when the consumer takes it
        if (ov_q && out_ready) begin
            ov_d = 1'b0;
        end

        if (act) begin
            if (act_code <= 4'd9) begin
                if (cnt_q < CNT_W'(NDIGITS)) begin
                    buf_d = (buf_q << 4) | W'(act_code);
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                case (act_code)
                    KEY_BKSP: begin
                        // Empty buffer stays all-blank; count saturates at 0
                        buf_d = (buf_q >> 4) | TOP_BLANK;
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    KEY_CLEAR: begin
                        buf_d = ALL_BLANK;
                        cnt_d = '0;
                    end
                    KEY_ENTER: begin
                        // Only a non-empty entry with a free output slot commits
                        if ((cnt_q != '0) && !ov_q) begin
                            oval_d = buf_q;
                            ov_d   = 1'b1;
                            buf_d  = ALL_BLANK;
                            cnt_d  = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    default: begin
                        err_d = 1'b1;
                    end
                endcase
            end
        end
    end

    // Entry buffer, committed value and strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= ALL_BLANK;
            cnt_q  <= '0;
            oval_q <= ALL_BLANK;
            ov_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            cnt_q  <= cnt_d;
            oval_q <= oval_d;
            ov_q   <= ov_d;
            err_q  <= err_d;
        end
    end

    assign buf_value = buf_q;
    assign digit_cnt = cnt_q;
    assign out_value = oval_q;
    assign out_valid = ov_q;
    assign err_pulse = err_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Scoreboard bench for keypad_entry_ctrl (DEBOUNCE_CYCLES=4, NDIGITS=3).
// Stimulus pushes the expected result of each key action; a monitor pops and
// compares whenever the DUT strobes key_pulse.
module tb_keypad_entry_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] onehot;
    logic [11:0] buf_value;
    logic [1:0]  digit_cnt;
    logic        key_pulse;
    logic [3:0]  key_code;
    logic [11:0] out_value;
    logic        out_valid;
    logic        out_ready;
    logic        err_pulse;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic [3:0]  code;
        logic        err;
        logic [11:0] bufv;
        logic [1:0]  cnt;
        logic        ov;
        logic [11:0] oval;
    } exp_t;

    exp_t sb[$];

    keypad_entry_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .NDIGITS         (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .onehot    (onehot),
        .buf_value (buf_value),
        .digit_cnt (digit_cnt),
        .key_pulse (key_pulse),
        .key_code  (key_code),
        .out_value (out_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_pulse (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        total_cnt++;
        $display("FAIL %s: got %0h expected no event at %0t", name, act, $time);
    endtask

    task automatic expect_key(input logic [3:0] code, input logic err, input logic [11:0] bufv,
                              input logic [1:0] cnt, input logic ov, input logic [11:0] oval);
        exp_t e;
        e.code = code; e.err = err; e.bufv = bufv; e.cnt = cnt; e.ov = ov; e.oval = oval;
        sb.push_back(e);
    endtask

    // Clean press: hold long enough to be acted on, then release and settle
    task automatic press(input logic [15:0] code);
        @(negedge clk);
        onehot = code;
        repeat (10) @(negedge clk);
        onehot = 16'h0000;
        repeat (12) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_buf"},       buf_value, 12'hFFF);
        check({tag, "_cnt"},       digit_cnt, 2'd0);
        check({tag, "_key_code"},  key_code,  4'hF);
        check({tag, "_key_pulse"}, key_pulse, 1'b0);
        check({tag, "_err"},       err_pulse, 1'b0);
        check({tag, "_ov"},        out_valid, 1'b0);
        check({tag, "_oval"},      out_value, 12'hFFF);
    endtask

    // Monitor: every key_pulse must match the oldest expected action
    always @(negedge clk) begin
        if (rst_n) begin
            if (key_pulse) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_key_pulse", {28'd0, key_code});
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("key_code",  key_code,  e.code);
                    check("err_pulse", err_pulse, e.err);
                    check("buf_value", buf_value, e.bufv);
                    check("digit_cnt", digit_cnt, e.cnt);
                    check("out_valid", out_valid, e.ov);
                    check("out_value", out_value, e.oval);
                end
            end else if (err_pulse) begin
                fail_now("err_without_key", 1);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        onehot    = 16'h0000;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Digit 1 with latency check: action lands on edge 7
        expect_key(4'd1, 1'b0, 12'hFF1, 2'd1, 1'b0, 12'hFFF);
        onehot = 16'h0080;
        repeat (6) @(posedge clk);
        #1 check("pre_latency_buf", buf_value, 12'hFFF);
        @(posedge clk);
        #1 check("latency_buf", buf_value, 12'hFF1);
        repeat (8) @(negedge clk);
        onehot = 16'h0000;
        repeat (12) @(negedge clk);

        // Digits 2, 3 fill the buffer; digit 4 overflows
        expect_key(4'd2, 1'b0, 12'hF12, 2'd2, 1'b0, 12'hFFF);
        press(16'h0040);
        expect_key(4'd3, 1'b0, 12'h123, 2'd3, 1'b0, 12'hFFF);
        press(16'h0020);
        expect_key(4'd4, 1'b1, 12'h123, 2'd3, 1'b0, 12'hFFF);
        press(16'h0800);

        // Short glitch must be rejected by the debouncer
        @(negedge clk);
        onehot = 16'h0020;
        repeat (3) @(negedge clk);
        onehot = 16'h0000;
        repeat (12) @(negedge clk);
        check("glitch_buf", buf_value, 12'h123);
        check("glitch_cnt", digit_cnt, 2'd3);

        // BKSP, CLEAR, ENTER on empty
        expect_key(4'hB, 1'b0, 12'hF12, 2'd2, 1'b0, 12'hFFF);
        press(16'h0002);
        expect_key(4'hC, 1'b0, 12'hFFF, 2'd0, 1'b0, 12'hFFF);
        press(16'h0004);
        expect_key(4'hA, 1'b1, 12'hFFF, 2'd0, 1'b0, 12'hFFF);
        press(16'h0001);

        // Build 042 and commit with the consumer stalled
        expect_key(4'd0, 1'b0, 12'hFF0, 2'd1, 1'b0, 12'hFFF);
        press(16'h0008);
        expect_key(4'd4, 1'b0, 12'hF04, 2'd2, 1'b0, 12'hFFF);
        press(16'h0800);
        expect_key(4'd2, 1'b0, 12'h042, 2'd3, 1'b0, 12'hFFF);
        press(16'h0040);
        expect_key(4'hA, 1'b0, 12'hFFF, 2'd0, 1'b1, 12'h042);
        press(16'h0001);
        // Editing continues while the output is pending; a second ENTER is refused
        expect_key(4'd5, 1'b0, 12'hFF5, 2'd1, 1'b1, 12'h042);
        press(16'h0400);
        expect_key(4'hA, 1'b1, 12'hFF5, 2'd1, 1'b1, 12'h042);
        press(16'h0001);
        check("stall_ov",   out_valid, 1'b1);
        check("stall_oval", out_value, 12'h042);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("accept_ov",   out_valid, 1'b0);
        check("accept_oval", out_value, 12'h042);
        @(negedge clk);
        out_ready = 1'b0;
        repeat (4) @(negedge clk);

        // Reset during PRESS_DB, key still held afterwards
        onehot = 16'h0200;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_state("rst_press");
        expect_key(4'd6, 1'b0, 12'hFF6, 2'd1, 1'b0, 12'hFFF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        onehot = 16'h0000;
        repeat (12) @(negedge clk);

        // Reset during HELD, key still held afterwards
        expect_key(4'd7, 1'b0, 12'hF67, 2'd2, 1'b0, 12'hFFF);
        onehot = 16'h8000;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_state("rst_held");
        expect_key(4'd7, 1'b0, 12'hFF7, 2'd1, 1'b0, 12'hFFF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        onehot = 16'h0000;
        repeat (12) @(negedge clk);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
